// File: rtl/div_if.sv
// div_if: handshake and result bus between the control unit and the divider.
// Optional macro DIV_UNSIGNED_EN adds the divU select line.
interface div_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             divCtrl;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divZero;
`ifdef DIV_UNSIGNED_EN
    logic             divU;
    modport master (output srcA, srcB, divCtrl, divU, input hi, lo, busy, done, divZero);
    modport slave  (input srcA, srcB, divCtrl, divU, output hi, lo, busy, done, divZero);
`else
    modport master (output srcA, srcB, divCtrl, input hi, lo, busy, done, divZero);
    modport slave  (input srcA, srcB, divCtrl, output hi, lo, busy, done, divZero);
`endif
endinterface

// File: rtl/div.sv
// div: sequential signed restoring divider, lo = quotient, hi = remainder.
// Optional macro DIV_UNSIGNED_EN enables unsigned division via divU.
module div #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic reset,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_qs;
    logic             r_rs;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic             w_u;
    logic             w_sa;
    logic             w_sb;
    logic             w_zb;
    logic [WIDTH-1:0] w_ma;
    logic [WIDTH-1:0] w_mb;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_sub;
    logic             w_ge;
`ifdef DIV_UNSIGNED_EN
    assign w_u = bus.divU;
`else
    assign w_u = 1'b0;
`endif
    assign w_sa  = bus.srcA[WIDTH-1] & ~w_u;
    assign w_sb  = bus.srcB[WIDTH-1] & ~w_u;
    assign w_zb  = bus.srcB == '0;
    assign w_ma  = w_sa ? -bus.srcA : bus.srcA;
    assign w_mb  = w_sb ? -bus.srcB : bus.srcB;
    // One extra bit keeps the trial subtraction exact for full-range unsigned divisors.
    assign w_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_sub = w_sh - {1'b0, r_div};
    assign w_ge  = ~w_sub[WIDTH];
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.divZero = r_dz;
    // Control FSM and datapath; divide-by-zero preloads rem/quo so FIX emits srcA and all ones unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_qs    <= 1'b0;
            r_rs    <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_busy <= r_state == RUN;
            case (r_state)
                IDLE: if (bus.divCtrl) begin
                    r_rem   <= w_zb ? bus.srcA : '0;
                    r_quo   <= w_zb ? '1 : w_ma;
                    r_div   <= w_mb;
                    r_qs    <= ~w_zb & (w_sa ^ w_sb);
                    r_rs    <= ~w_zb & w_sa;
                    r_zero  <= w_zb;
                    r_cnt   <= '0;
                    r_dz    <= 1'b0;
                    r_state <= w_zb ? FIX : RUN;
                end
                RUN: begin
                    r_rem   <= w_ge ? w_sub[WIDTH-1:0] : w_sh[WIDTH-1:0];
                    r_quo   <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= r_cnt == CW'(WIDTH - 1) ? FIX : RUN;
                end
                FIX: begin
                    r_lo    <= r_qs ? -r_quo : r_quo;
                    r_hi    <= r_rs ? -r_rem : r_rem;
                    r_dz    <= r_zero;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for the sequential divider.
module tb_div;
    logic        clk = 1'b0;
    logic        reset;
    int          checks = 0;
    int          failures = 0;
    logic [64:0] q[$];
    logic [64:0] exp_r;
    logic [64:0] drop_r;

    div_if #(.WIDTH(32)) bus ();
    div #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (b == 32'd0) return {1'b1, a, 32'hFFFFFFFF};
        if (u) return {1'b0, a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
        return {1'b0, 32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_r = q.pop_front();
                check("hi", bus.hi, exp_r[63:32]);
                check("lo", bus.lo, exp_r[31:0]);
                check("divZero", bus.divZero, exp_r[64]);
            end
        end
    end

    task automatic set_u(input logic u);
`ifdef DIV_UNSIGNED_EN
        bus.divU = u;
`endif
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic u, input bit mid);
        int n;
        int bc;
        bus.srcA    = a;
        bus.srcB    = b;
        bus.divCtrl = 1'b1;
        set_u(u);
        q.push_back(model(a, b, u));
        @(negedge clk);
        bus.divCtrl = 1'b0;
        bus.srcA    = ~a;
        bus.srcB    = b + 32'd1;
        n  = 0;
        bc = 0;
        while (!bus.done && n < 100) begin
            bc += int'(bus.busy);
            if (mid) bus.divCtrl = (n == 5);
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), b == 32'd0 ? 64'd1 : 64'd33);
        check("busy_cycles", 64'(bc), b == 32'd0 ? 64'd0 : 64'd32);
        check("busy_at_done", bus.busy, 64'd0);
    endtask

    initial begin
        reset       = 1'b0;
        bus.divCtrl = 1'b0;
        bus.srcA    = '0;
        bus.srcB    = '0;
        set_u(1'b0);
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi, 64'd0);
        check("rst_lo", bus.lo, 64'd0);
        check("rst_busy", bus.busy, 64'd0);
        check("rst_done", bus.done, 64'd0);
        check("rst_divZero", bus.divZero, 64'd0);
        reset = 1'b1;
        run(32'd7, 32'd2, 1'b0, 1'b0);
        run(32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        run(32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
        run(32'd5, 32'd0, 1'b0, 1'b0);
        run(32'd9, 32'd3, 1'b0, 1'b0);
        run(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run(32'd0, 32'd7, 1'b0, 1'b0);
        run(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 1'b0);
        run(32'd100, 32'd7, 1'b0, 1'b1);
        bus.srcA    = 32'd100;
        bus.srcB    = 32'd7;
        bus.divCtrl = 1'b1;
        q.push_back(model(32'd100, 32'd7, 1'b0));
        @(negedge clk);
        bus.divCtrl = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drop_r = q.pop_back();
        check("abort_busy", bus.busy, 64'd0);
        check("abort_done", bus.done, 64'd0);
        check("abort_hi", bus.hi, 64'd0);
        check("abort_lo", bus.lo, 64'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(q.size()), 64'd0);
        run(32'd100, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run($urandom(), $urandom_range(1, 1000) * ((i % 2 == 1) ? -1 : 1), 1'b0, 1'b0);
        end
`ifdef DIV_UNSIGNED_EN
        run(32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        run(32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        run(32'hFFFFFFF0, 32'd0, 1'b1, 1'b0);
        run(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0);
`endif
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
